// File: rtl/descrambler_sync.sv
`default_nettype none
// ============================================================================
// Module   : descrambler_sync
// Function : Frame-synchronised x^31 + x^28 + 1 additive descrambler with
//            sliding sync hunt and flywheel lock tracking.
// Revision : 1.0 - initial release
// ============================================================================
module descrambler_sync #(
    parameter int                  SYNC_LEN    = 16,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 16'hF628,
    parameter int                  PAYLOAD_LEN = 64,
    parameter int                  LOCK_COUNT  = 2,
    parameter int                  MISS_COUNT  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] seed,
    input  logic        data_in,
    output logic        data_out,
    output logic        data_valid,
    output logic        sync_pulse,
    output logic        sync_err,
    output logic        locked
);

    localparam int c_fill_w = $clog2(SYNC_LEN + 1);
    localparam int c_cnt_max = (PAYLOAD_LEN > SYNC_LEN) ? PAYLOAD_LEN : SYNC_LEN;
    localparam int c_cnt_w  = $clog2(c_cnt_max);
    localparam int c_good_w = $clog2(LOCK_COUNT + 1);
    localparam int c_miss_w = $clog2(MISS_COUNT + 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    state_t                r_state,      w_state_nxt;
    logic [30:0]           r_lfsr,       w_lfsr_nxt;
    logic [SYNC_LEN-1:0]   r_sr,         w_sr_nxt;
    logic [c_fill_w-1:0]   r_fill,       w_fill_nxt;
    logic [c_cnt_w-1:0]    r_bit_cnt,    w_bit_cnt_nxt;
    logic [c_good_w-1:0]   r_good_cnt,   w_good_cnt_nxt;
    logic [c_miss_w-1:0]   r_miss_cnt,   w_miss_cnt_nxt;
    logic                  r_data_out,   w_data_out_nxt;
    logic                  r_data_valid, w_data_valid_nxt;
    logic                  r_sync_pulse, w_sync_pulse_nxt;
    logic                  r_sync_err,   w_sync_err_nxt;
    logic                  r_locked,     w_locked_nxt;

    logic [SYNC_LEN-1:0]   w_sr_shift;
    logic [30:0]           w_lfsr_step;
    logic                  w_sync_hit;
    logic [c_good_w-1:0]   w_good_inc;
    logic [c_miss_w-1:0]   w_miss_inc;
    logic                  w_unused_seed_msb;

    assign w_unused_seed_msb = seed[31];

    // A match is judged on the window including the current bit, so the
    // fill requirement is met once SYNC_LEN-1 earlier bits have arrived.
    assign w_sr_shift  = {r_sr[SYNC_LEN-2:0], data_in};
    assign w_sync_hit  = (r_fill >= c_fill_w'(SYNC_LEN - 1)) && (w_sr_shift == SYNC_WORD);
    assign w_lfsr_step = {r_lfsr[29:0], r_lfsr[30] ^ r_lfsr[27]};
    assign w_good_inc  = (r_good_cnt == c_good_w'(LOCK_COUNT)) ? r_good_cnt
                                                               : r_good_cnt + 1'b1;
    assign w_miss_inc  = r_miss_cnt + 1'b1;

    always_comb begin
        w_state_nxt      = r_state;
        w_lfsr_nxt       = r_lfsr;
        w_sr_nxt         = r_sr;
        w_fill_nxt       = r_fill;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_good_cnt_nxt   = r_good_cnt;
        w_miss_cnt_nxt   = r_miss_cnt;
        w_data_out_nxt   = r_data_out;
        w_data_valid_nxt = 1'b0;
        w_sync_pulse_nxt = 1'b0;
        w_sync_err_nxt   = 1'b0;
        w_locked_nxt     = r_locked;

        if (enable) begin
            w_sr_nxt   = w_sr_shift;
            w_fill_nxt = (r_fill == c_fill_w'(SYNC_LEN)) ? r_fill : r_fill + 1'b1;

            case (r_state)
                ST_HUNT: begin
                    if (w_sync_hit) begin
                        w_lfsr_nxt       = seed[30:0];
                        w_good_cnt_nxt   = c_good_w'(1);
                        w_miss_cnt_nxt   = '0;
                        w_sync_pulse_nxt = 1'b1;
                        w_bit_cnt_nxt    = '0;
                        w_state_nxt      = ST_PAYLOAD;
                        if (LOCK_COUNT == 1) begin
                            w_locked_nxt = 1'b1;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    w_data_out_nxt   = data_in ^ r_lfsr[30];
                    w_data_valid_nxt = 1'b1;
                    w_lfsr_nxt       = w_lfsr_step;
                    if (r_bit_cnt == c_cnt_w'(PAYLOAD_LEN - 1)) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = ST_CHECK;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end

                ST_CHECK: begin
                    if (r_bit_cnt != c_cnt_w'(SYNC_LEN - 1)) begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end else begin
                        w_bit_cnt_nxt = '0;
                        if (w_sr_shift == SYNC_WORD) begin
                            w_sync_pulse_nxt = 1'b1;
                            w_good_cnt_nxt   = w_good_inc;
                            w_miss_cnt_nxt   = '0;
                            w_lfsr_nxt       = seed[30:0];
                            w_state_nxt      = ST_PAYLOAD;
                            if (w_good_inc >= c_good_w'(LOCK_COUNT)) begin
                                w_locked_nxt = 1'b1;
                            end
                        end else begin
                            w_sync_err_nxt = 1'b1;
                            w_good_cnt_nxt = '0;
                            if (!r_locked) begin
                                w_state_nxt = ST_HUNT;
                            end else if (w_miss_inc == c_miss_w'(MISS_COUNT)) begin
                                w_locked_nxt   = 1'b0;
                                w_miss_cnt_nxt = '0;
                                w_state_nxt    = ST_HUNT;
                            end else begin
                                // Flywheel: trust the frame timing through a bad sync word
                                w_miss_cnt_nxt = w_miss_inc;
                                w_lfsr_nxt     = seed[30:0];
                                w_state_nxt    = ST_PAYLOAD;
                            end
                        end
                    end
                end

                default: begin
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_HUNT;
            r_lfsr       <= '0;
            r_sr         <= '0;
            r_fill       <= '0;
            r_bit_cnt    <= '0;
            r_good_cnt   <= '0;
            r_miss_cnt   <= '0;
            r_data_out   <= 1'b0;
            r_data_valid <= 1'b0;
            r_sync_pulse <= 1'b0;
            r_sync_err   <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_sr         <= w_sr_nxt;
            r_fill       <= w_fill_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_good_cnt   <= w_good_cnt_nxt;
            r_miss_cnt   <= w_miss_cnt_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_sync_pulse <= w_sync_pulse_nxt;
            r_sync_err   <= w_sync_err_nxt;
            r_locked     <= w_locked_nxt;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign sync_pulse = r_sync_pulse;
    assign sync_err   = r_sync_err;
    assign locked     = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_descrambler_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_descrambler_sync
// Function : Directed, table-driven bench for descrambler_sync.
// Revision : 1.0 - initial release
// ============================================================================
module tb_descrambler_sync;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] seed;
    logic        data_in;
    logic        data_out;
    logic        data_valid;
    logic        sync_pulse;
    logic        sync_err;
    logic        locked;

    int n_checks = 0;
    int n_pass   = 0;

    bit       gap_mode = 1'b0;
    bit [3:0] gap_pat  = 4'b1001;
    int       gap_pos  = 0;
    int       gap_errs = 0;
    int       gap_cycles = 0;

    typedef struct {
        logic [15:0] sw;
        bit          exp_pulse;
        bit          exp_err;
        bit          exp_locked;
        bit          exp_payload;
    } frame_t;

    frame_t frames [11];

    descrambler_sync dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .seed       (seed),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sync_pulse (sync_pulse),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, n_pass=%0d required=%0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_bit(input logic en, input logic d);
        enable  = en;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    // Sends one line bit; in gap mode disabled cycles are inserted per gap_pat.
    task automatic send_data(input logic d);
        logic hold_do, hold_lk;
        if (gap_mode) begin
            while (!gap_pat[gap_pos]) begin
                hold_do = data_out;
                hold_lk = locked;
                send_bit(1'b0, 1'($urandom % 2));
                gap_cycles++;
                if (data_valid !== 1'b0 || sync_pulse !== 1'b0 || sync_err !== 1'b0 ||
                    data_out !== hold_do || locked !== hold_lk)
                    gap_errs++;
                gap_pos = (gap_pos + 1) % 4;
            end
            gap_pos = (gap_pos + 1) % 4;
        end
        send_bit(1'b1, d);
    endtask

    task automatic do_reset(input int n);
        reset   = 1'b1;
        gap_pos = 0;
        repeat (n) send_bit(1'b1, 1'($urandom % 2));
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"},   {31'd0, data_out},   32'd0);
        check({tag, "_data_valid"}, {31'd0, data_valid}, 32'd0);
        check({tag, "_sync_pulse"}, {31'd0, sync_pulse}, 32'd0);
        check({tag, "_sync_err"},   {31'd0, sync_err},   32'd0);
        check({tag, "_locked"},     {31'd0, locked},     32'd0);
    endtask

    task automatic send_sync(input logic [15:0] sw, output int quiet_errs);
        quiet_errs = 0;
        for (int i = 15; i >= 0; i--) begin
            send_data(sw[i]);
            if (i != 0 && (sync_pulse !== 1'b0 || sync_err !== 1'b0 || data_valid !== 1'b0))
                quiet_errs++;
        end
    endtask

    // Plaintext is zero unless forced; forced bits go on the line verbatim.
    task automatic send_payload(input logic [31:0] sd, input int n,
                                input logic [63:0] fmask, input logic [63:0] fval,
                                output int errs, output logic [63:0] got);
        logic [30:0] ref_lfsr;
        logic        ks, raw, exp;
        ref_lfsr = sd[30:0];
        errs = 0;
        got  = '0;
        for (int i = 0; i < n; i++) begin
            ks  = ref_lfsr[30];
            raw = fmask[i] ? fval[i] : ks;
            exp = raw ^ ks;
            ref_lfsr = {ref_lfsr[29:0], ref_lfsr[30] ^ ref_lfsr[27]};
            send_data(raw);
            got[i] = data_out;
            if (data_valid !== 1'b1 || data_out !== exp || sync_pulse !== 1'b0 || sync_err !== 1'b0)
                errs++;
        end
    endtask

    task automatic send_idle(input int n, output int errs);
        errs = 0;
        for (int i = 0; i < n; i++) begin
            send_data(1'b0);
            if (data_valid !== 1'b0 || sync_pulse !== 1'b0 || sync_err !== 1'b0)
                errs++;
        end
    endtask

    task automatic run_frame(input string tag, input frame_t f);
        int          q, e;
        logic [63:0] got;
        send_sync(f.sw, q);
        check({tag, "_sync_quiet"}, q, 0);
        check({tag, "_sync_pulse"}, {31'd0, sync_pulse}, {31'd0, f.exp_pulse});
        check({tag, "_sync_err"},   {31'd0, sync_err},   {31'd0, f.exp_err});
        check({tag, "_locked"},     {31'd0, locked},     {31'd0, f.exp_locked});
        if (f.exp_payload) send_payload(seed, 64, 64'd0, 64'd0, e, got);
        else               send_idle(64, e);
        check({tag, "_payload"}, e, 0);
    endtask

    initial begin
        int          e, q;
        logic [63:0] got;
        logic [63:0] emask, eval;
        logic [15:0] sw_tmp;
        logic        exp_bit;

        frames[0]  = '{16'hF628, 1'b1, 1'b0, 1'b0, 1'b1};
        frames[1]  = '{16'hF628, 1'b1, 1'b0, 1'b1, 1'b1};
        frames[2]  = '{16'hF628, 1'b1, 1'b0, 1'b1, 1'b1};
        frames[3]  = '{16'hF628, 1'b1, 1'b0, 1'b1, 1'b1};
        frames[4]  = '{16'hF629, 1'b0, 1'b1, 1'b1, 1'b1};
        frames[5]  = '{16'hF628, 1'b1, 1'b0, 1'b1, 1'b1};
        frames[6]  = '{16'hF629, 1'b0, 1'b1, 1'b1, 1'b1};
        frames[7]  = '{16'hF629, 1'b0, 1'b1, 1'b1, 1'b1};
        frames[8]  = '{16'hF629, 1'b0, 1'b1, 1'b0, 1'b0};
        frames[9]  = '{16'hF628, 1'b1, 1'b0, 1'b0, 1'b1};
        frames[10] = '{16'hF628, 1'b1, 1'b0, 1'b1, 1'b1};

        reset   = 1'b1;
        enable  = 1'b0;
        data_in = 1'b0;
        seed    = 32'h1234_5678;

        // Reset and partial sync word before the window is full
        do_reset(3);
        check_all_zero("reset");
        sw_tmp = 16'hF628;
        q = 0;
        for (int i = 15; i >= 4; i--) begin
            send_data(sw_tmp[i]);
            if (sync_pulse !== 1'b0) q++;
        end
        send_idle(4, e);
        check("prefill_no_pulse", q + e, 0);

        // Loopback, flywheel, loss of lock and relock
        for (int i = 0; i < 11; i++) run_frame($sformatf("frame%0d", i), frames[i]);

        // Keystream from seed 1, then a sync pattern embedded in a payload
        do_reset(1);
        seed = 32'h0000_0001;
        send_idle(4, e);
        send_sync(16'hF628, q);
        check("ks_sync_pulse", {31'd0, sync_pulse}, 32'd1);
        send_payload(seed, 64, {64{1'b1}}, 64'd0, e, got);
        check("ks_payload", e, 0);
        for (int i = 0; i < 31; i++) begin
            exp_bit = (i == 30);
            check($sformatf("keystream_bit%0d", i + 1), {31'd0, got[i]}, {31'd0, exp_bit});
        end
        send_sync(16'hF628, q);
        check("embed_sync_pulse", {31'd0, sync_pulse}, 32'd1);
        emask = '0;
        eval  = '0;
        for (int k = 0; k < 16; k++) begin
            emask[10+k] = 1'b1;
            eval[10+k]  = sw_tmp[15-k];
        end
        send_payload(seed, 64, emask, eval, e, got);
        check("embed_no_pulse", e, 0);
        send_sync(16'hF628, q);
        check("embed_next_sync", {31'd0, sync_pulse}, 32'd1);
        check("embed_next_quiet", q, 0);

        // Enable pattern 1,0,0,1 over the loopback stream
        do_reset(1);
        seed     = 32'h1234_5678;
        gap_mode = 1'b1;
        send_idle(4, e);
        for (int i = 0; i < 4; i++) run_frame($sformatf("gap%0d", i), frames[i]);
        gap_mode = 1'b0;
        check("gap_disabled_cycles", gap_errs, 0);
        check("gap_cycles_seen", {31'd0, gap_cycles > 0}, 32'd1);

        // Reset in the middle of a payload
        send_sync(16'hF628, q);
        check("mid_pre_locked", {31'd0, locked}, 32'd1);
        send_payload(seed, 30, 64'd0, 64'd0, e, got);
        check("mid_pre_payload", e, 0);
        do_reset(1);
        check_all_zero("mid_reset");
        send_idle(8, e);
        check("mid_hunt_idle", e, 0);
        run_frame("relock0", frames[9]);
        run_frame("relock1", frames[10]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
